// File: rtl/idli_sqi_resp_m.sv
// rtl/idli_sqi_resp_m.sv - SQI serial-SRAM responder serving READ/WRITE from an internal byte array
module idli_sqi_resp_m #(
  parameter int ADDR_W = 8
) (
  input  logic       i_resp_sck,
  input  logic       i_top_rst_n,
  input  logic       i_resp_cs,
  input  logic [3:0] i_resp_sio,
  output logic [3:0] o_resp_sio,
  output logic       o_resp_sio_oe
);

  typedef logic [3:0] slice_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_RD_DATA,
    ST_WR_DATA,
    ST_IGNORE
  } state_t;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  state_t              state_q;
  state_t              state_d;
  slice_t              cmd_hi_q;
  logic                is_rd_q;
  logic [1:0]          nib_cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                phase_q;
  slice_t              wr_hi_q;
  logic [7:0]          cmd_full;
  logic                mem_we;
  logic [7:0]          rd_byte;

  logic [7:0] mem [0:(2**ADDR_W)-1];

  assign cmd_full = {cmd_hi_q, i_resp_sio};
  assign rd_byte  = mem[addr_q];

  // State register; CS high holds the FSM in IDLE without waiting for a clock.
  always_ff @(posedge i_resp_sck or negedge i_top_rst_n or posedge i_resp_cs) begin
    if (!i_top_rst_n) begin
      state_q <= ST_IDLE;
    end else if (i_resp_cs) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and memory write strobe (second nibble of each write byte).
  always_comb begin
    state_d = state_q;
    mem_we  = 1'b0;
    case (state_q)
      ST_IDLE:  state_d = ST_CMD;
      ST_CMD: begin
        if (cmd_full == CMD_READ || cmd_full == CMD_WRITE) begin
          state_d = ST_ADDR;
        end else begin
          state_d = ST_IGNORE;
        end
      end
      ST_ADDR: begin
        if (nib_cnt_q == 2'd3) begin
          state_d = is_rd_q ? ST_DUMMY : ST_WR_DATA;
        end
      end
      ST_DUMMY: begin
        if (nib_cnt_q == 2'd1) begin
          state_d = ST_RD_DATA;
        end
      end
      ST_RD_DATA: state_d = ST_RD_DATA;
      ST_WR_DATA: begin
        state_d = ST_WR_DATA;
        mem_we  = phase_q & ~i_resp_cs;
      end
      ST_IGNORE: state_d = ST_IGNORE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Rising-edge datapath: command capture, address shift-in, nibble counters and byte phase.
  always_ff @(posedge i_resp_sck or negedge i_top_rst_n or posedge i_resp_cs) begin
    if (!i_top_rst_n) begin
      cmd_hi_q  <= '0;
      is_rd_q   <= 1'b0;
      nib_cnt_q <= '0;
      addr_q    <= '0;
      phase_q   <= 1'b0;
      wr_hi_q   <= '0;
    end else if (i_resp_cs) begin
      cmd_hi_q  <= '0;
      is_rd_q   <= 1'b0;
      nib_cnt_q <= '0;
      addr_q    <= '0;
      phase_q   <= 1'b0;
      wr_hi_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cmd_hi_q  <= i_resp_sio;
          nib_cnt_q <= '0;
        end
        ST_CMD: begin
          is_rd_q   <= (cmd_full == CMD_READ);
          nib_cnt_q <= '0;
        end
        ST_ADDR: begin
          // Shifting all four nibbles through an ADDR_W-bit register keeps only
          // the low bits, which gives the required address aliasing for free.
          addr_q    <= {addr_q[ADDR_W-5:0], i_resp_sio};
          nib_cnt_q <= (nib_cnt_q == 2'd3) ? 2'd0 : nib_cnt_q + 2'd1;
          phase_q   <= 1'b0;
        end
        ST_DUMMY: begin
          nib_cnt_q <= nib_cnt_q + 2'd1;
          phase_q   <= 1'b0;
        end
        ST_RD_DATA: begin
          phase_q <= ~phase_q;
          if (phase_q) begin
            addr_q <= addr_q + 1'b1;
          end
        end
        ST_WR_DATA: begin
          phase_q <= ~phase_q;
          if (!phase_q) begin
            wr_hi_q <= i_resp_sio;
          end else begin
            addr_q <= addr_q + 1'b1;
          end
        end
        default: begin
          nib_cnt_q <= nib_cnt_q;
        end
      endcase
    end
  end

  // Byte array write; contents survive reset so data persists across resets.
  always_ff @(posedge i_resp_sck) begin
    if (mem_we) begin
      mem[addr_q] <= {wr_hi_q, i_resp_sio};
    end
  end

  // Falling-edge drive gives the initiator a half-cycle of setup before it samples.
  always_ff @(negedge i_resp_sck or negedge i_top_rst_n or posedge i_resp_cs) begin
    if (!i_top_rst_n) begin
      o_resp_sio    <= 4'h0;
      o_resp_sio_oe <= 1'b0;
    end else if (i_resp_cs) begin
      o_resp_sio    <= 4'h0;
      o_resp_sio_oe <= 1'b0;
    end else if (state_q == ST_RD_DATA) begin
      o_resp_sio    <= phase_q ? rd_byte[3:0] : rd_byte[7:4];
      o_resp_sio_oe <= 1'b1;
    end else begin
      o_resp_sio    <= 4'h0;
      o_resp_sio_oe <= 1'b0;
    end
  end

endmodule

// File: doc/idli_sqi_resp_m.md
# idli_sqi_resp_m

Synthesisable SQI serial-SRAM responder: the memory-side end of the quad-SPI link that the core's SQI controller drives on its `lo`/`hi` memory ports. It decodes READ and WRITE commands in sequential mode over a 4-bit SIO bus and serves data from an internal byte array. It is used as the memory model in the bench and as the on-die fallback memory for FPGA bring-up. One instance serves one chip-select.

## Interface

- `ADDR_W`, default 8: internal array address width. The array holds 2^ADDR_W bytes. Only the low ADDR_W bits of the 16-bit bus address are used, so the array aliases.
- `i_resp_sck`, input, 1: serial clock from the initiator. It is the block's only clock.
- `i_top_rst_n`, input, 1: reset, asynchronous, active-low.
- `i_resp_cs`, input, 1: chip select, low selects. While high, the FSM is held in IDLE asynchronously.
- `i_resp_sio`, input, 4 (`slice_t`): command, address and write data from the initiator.
- `o_resp_sio`, output, 4 (`slice_t`): read data to the initiator.
- `o_resp_sio_oe`, output, 1: high while the responder drives `o_resp_sio`.

## Operation

- The bus is always in SQI mode. No mode-switch commands exist.
- Every transfer sends the high nibble first.
- States and nibble counts (one nibble per SCK rising edge):
  - IDLE → CMD: entered on the first rising edge with CS low.
  - CMD, 2 nibbles: 0x03 → ADDR (read); 0x02 → ADDR (write); any other value → IGNORE.
  - ADDR, 4 nibbles: 16-bit address, MSB nibble first. Loads `addr_q`.
  - After ADDR: a read goes to DUMMY; a write goes to WR_DATA.
  - DUMMY, 2 nibbles: input is ignored. Then → RD_DATA.
  - RD_DATA: streams bytes until CS goes high.
  - WR_DATA: accepts bytes until CS goes high.
  - IGNORE: SIO is not driven and no writes occur until CS goes high.
- Read path:
  - The byte `mem[addr_q]` is driven high nibble, then low nibble.
  - `addr_q` increments after the low nibble.
- Write path:
  - The first nibble of each byte is latched into `wr_hi_q`.
  - On the second nibble, `mem[addr_q]` is written with `{wr_hi_q, sio}` and `addr_q` increments.
  - If CS rises after only one nibble of a byte, that partial byte is discarded. Memory is unchanged.
- Address arithmetic: `addr_q` is ADDR_W bits and increments modulo 2^ADDR_W. 0xFF+1 wraps to 0x00 when ADDR_W=8.
- `i_top_rst_n` low: FSM goes to IDLE and all counters clear. Outputs go to reset values. Memory contents are **not** reset.
- CS high at any point forces IDLE, `o_resp_sio_oe`=0 and `o_resp_sio`=0. This is asynchronous and also applies mid-command, mid-address or mid-data.
- Reset values: `o_resp_sio`=4'h0, `o_resp_sio_oe`=0.

## Timing

- Sampling: `i_resp_sio` and `i_resp_cs` are sampled on the SCK rising edge.
- Drive: `o_resp_sio` and `o_resp_sio_oe` change on the SCK falling edge only, giving a half-cycle setup for the initiator.
- Read latency:
  - Rising edges 1–2: command. Edges 3–6: address. Edges 7–8: dummy.
  - The falling edge after rising edge 8 asserts `o_resp_sio_oe` and drives the high nibble of byte 0.
  - The initiator samples that nibble on rising edge 9 and the low nibble on rising edge 10.
  - From then on, one new nibble is driven per falling edge with no gaps.
- Write timing: bytes land in memory on rising edges 8, 10, 12, … after CS falls. Read-after-write on the same address in a later transaction returns the new value.
- `o_resp_sio_oe` is never high outside RD_DATA, including during DUMMY.
- Back-to-back transactions: CS high for ≥1 SCK period between them. The second transaction decodes independently of the first.

## Test plan

- Write then read:
  - Stimulus: WRITE 0x02, address 0x0010, data 0xA5, 0x3C, then CS high.
  - Then: READ 0x03, address 0x0010, 2 dummy nibbles, 4 data cycles.
  - Required response: SIO returns A,5,3,C. `oe` rises on the falling edge after rising edge 8.
- Address wrap:
  - Stimulus: with ADDR_W=8, write 0x11 at 0x00FF and 0x22 at 0x0000. Then read 2 bytes from 0x00FF.
  - Required response: 1,1,2,2. A read from 0x01FF also returns 0x11 (aliasing).
- Illegal command:
  - Stimulus: command 0xFF followed by 12 nibbles of 0xF.
  - Required response: `oe` stays 0 throughout. A subsequent read of 0x0010 still returns 0xA5.
- CS abort:
  - Stimulus: raise CS after 3 address nibbles. Separately, raise CS after 1 write-data nibble of 0x7 to address 0x0020.
  - Required response: `oe`=0 and `sio`=0 immediately. Memory at 0x0020 is unchanged. The next READ transaction decodes correctly.
- Reset mid-read:
  - Stimulus: assert `i_top_rst_n` low during RD_DATA.
  - Required response: `o_resp_sio`=0 and `oe`=0 asynchronously. After release, a new READ returns the previously written data (memory is preserved).
- Sequential stream:
  - Stimulus: write 16 bytes 0x00..0x0F at 0x0040, then read 16 bytes from 0x0040.
  - Required response: nibble stream 0,0,0,1,…,0,F with no gaps.
